enigma_stream_ctrl: RTL

Character-stream sequencer for the Enigma datapath. It accepts ASCII bytes from the UART receive side and maps letters to 5-bit character codes. It issues one code at a time to the Enigma core with a single-cycle step pulse, waits a fixed settle time, then samples the core's result. The result is converted back to ASCII and buffered in a small FIFO for the UART transmit side, which replaces the free-running XOR-based pulse generation with a proper handshake-driven scheduler.

---
 rtl/enigma_stream_ctrl_if.sv | 20 ++
 rtl/enigma_stream_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/enigma_stream_ctrl_if.sv
// Byte-stream handshake bundle: UART receive side into the sequencer, FIFO head out to the UART transmitter.
// A transfer happens on a rising clk edge where valid and ready are both high; valid must not depend on ready.
interface enigma_stream_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/enigma_stream_ctrl.sv
// Enigma character sequencer: letter -> code, one step pulse per character, settle wait, result -> ASCII FIFO.
// Optional feature: ENIGMA_PASSTHRU_NONALPHA_EN forwards non-letters to tx instead of dropping them.
module enigma_stream_ctrl #(
    parameter int SETTLE_CYCLES = 3,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset,
    enigma_stream_ctrl_if.slave bus,
    output logic [4:0]          enc_char,
    output logic                enc_pulse,
    input  logic [4:0]          enc_result,
    output logic                busy,
    output logic [15:0]         char_count,
    output logic                err,
    output logic [1:0]          state_dbg_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  enc_char_q, enc_char_d;
    logic [15:0] count_q, count_d;
    logic        err_q, err_d;

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic        fifo_full, fifo_empty, push, pop;
    logic [7:0]  push_data;

    logic        is_upper, is_lower, is_letter;
    logic [4:0]  letter_code;
    logic [7:0]  result_byte;

    assign is_upper    = (bus.rx_data >= 8'h41) && (bus.rx_data <= 8'h5A);
    assign is_lower    = (bus.rx_data >= 8'h61) && (bus.rx_data <= 8'h7A);
    assign is_letter   = is_upper || is_lower;
    assign letter_code = is_upper ? 5'(bus.rx_data - 8'h41) : 5'(bus.rx_data - 8'h61);
    assign result_byte = (enc_result > 5'd25) ? 8'h3F : (8'h41 + {3'b000, enc_result});

    // Pointers carry one extra wrap bit so full and empty are distinguishable at equal indices.
    assign fifo_empty  = (wr_q == rd_q);
    assign fifo_full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop         = !fifo_empty && bus.tx_ready;
    assign bus.tx_valid = !fifo_empty;
    assign bus.tx_data  = fifo_empty ? 8'h00 : mem_q[rd_q[AW-1:0]];

    assign enc_char    = enc_char_q;
    assign char_count  = count_q;
    assign err         = err_q;
    assign busy        = (state_q != IDLE);
    assign state_dbg_o = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            enc_char_q <= 5'd0;
            count_q    <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            enc_char_q <= enc_char_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        enc_char_d   = enc_char_q;
        count_d      = count_q;
        err_d        = err_q;
        push         = 1'b0;
        push_data    = 8'h00;
        enc_pulse    = 1'b0;
        bus.rx_ready = 1'b0;
        case (state_q)
            IDLE: begin
                bus.rx_ready = !fifo_full;
                if (bus.rx_valid && !fifo_full) begin
                    if (is_letter) begin
                        enc_char_d = letter_code;
                        state_d    = ISSUE;
                    end else begin
`ifdef ENIGMA_PASSTHRU_NONALPHA_EN
                        push      = 1'b1;
                        push_data = bus.rx_data;
`endif
                    end
                end
            end
            ISSUE: begin
                enc_pulse = 1'b1;
                cnt_d     = 4'(SETTLE_CYCLES - 1);
                state_d   = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CAPTURE: begin
                // A slot is always free here: acceptance required one and nothing else pushes meanwhile.
                push      = 1'b1;
                push_data = result_byte;
                count_d   = count_q + 16'd1;
                if (enc_result > 5'd25) begin
                    err_d = 1'b1;
                end
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + {{AW{1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

endmodule
